// File: rtl/btb_predictor_if.sv
// Fetch/execute side bundle for btb_predictor.
// master: pipeline (IF lookup, EX training); slave: the predictor itself.
interface btb_predictor_if #(
  parameter int ADDR_W = 32
);
  logic              lookup_pc_unused_guard;
  logic [ADDR_W-1:0] lookup_pc;
  logic              pred_taken;
  logic [ADDR_W-1:0] next_pc;

  logic              upd_valid;
  logic [ADDR_W-1:0] upd_pc;
  logic              upd_taken;
  logic [ADDR_W-1:0] upd_target;
  logic              upd_pred_taken;
  logic [ADDR_W-1:0] upd_pred_target;
  logic              inval;

  logic              flush;
  logic [ADDR_W-1:0] redirect_pc;

  logic [31:0]       stat_lookups;
  logic [31:0]       stat_mispredicts;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, inval,
    input  pred_taken, next_pc, flush, redirect_pc,
           stat_lookups, stat_mispredicts
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, inval,
    output pred_taken, next_pc, flush, redirect_pc,
           stat_lookups, stat_mispredicts
  );
endinterface

// File: rtl/btb_predictor.sv
// Direct-mapped, tagged branch target buffer with saturating direction
// counters. Lookup is combinational off the registered table; training
// happens at the rising edge with a single write port. Misprediction
// flush/redirect are combinational on the EX-side update inputs.
//
// Optional build macro: BTB_STATS_EN adds saturating lookup/mispredict
// counters; without it both stat ports read 0 and no registers exist.
module btb_predictor #(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 32,
  parameter int CNT_W   = 2
) (
  input logic               clk,
  input logic               rst_n,
  btb_predictor_if.slave    bus
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = ADDR_W - IDX_W - 2;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;

  logic              valid_q  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [ADDR_W-1:0] target_q [ENTRIES];
  logic [CNT_W-1:0]  cnt_q    [ENTRIES];

  logic [IDX_W-1:0]  lk_idx;
  logic [TAG_W-1:0]  lk_tag;
  logic              lk_hit;
  logic              lk_taken;

  logic [IDX_W-1:0]  up_idx;
  logic [TAG_W-1:0]  up_tag;
  logic              up_hit;
  logic [CNT_W-1:0]  up_cnt;
  logic [CNT_W-1:0]  up_cnt_nxt;

  logic              flush;

  // pc[1:0] never participates in index or tag.
  logic unused_pc_lsbs;
  assign unused_pc_lsbs = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0]};

  assign lk_idx   = bus.lookup_pc[IDX_W+1:2];
  assign lk_tag   = bus.lookup_pc[ADDR_W-1:IDX_W+2];
  assign lk_hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign lk_taken = lk_hit && cnt_q[lk_idx][CNT_W-1];

  assign bus.pred_taken = lk_taken;
  assign bus.next_pc    = lk_taken ? target_q[lk_idx]
                                   : bus.lookup_pc + ADDR_W'(4);

  assign up_idx = bus.upd_pc[IDX_W+1:2];
  assign up_tag = bus.upd_pc[ADDR_W-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_cnt = cnt_q[up_idx];

  // Saturating step of the trained entry's direction counter.
  always_comb begin
    up_cnt_nxt = up_cnt;
    if (bus.upd_taken) begin
      if (up_cnt != CNT_MAX) up_cnt_nxt = up_cnt + 1'b1;
    end else begin
      if (up_cnt != '0) up_cnt_nxt = up_cnt - 1'b1;
    end
  end

  // Misprediction: wrong direction, or taken with a stale target.
  // Held low while in reset so a pending EX update cannot kill the pipe.
  assign flush = rst_n && bus.upd_valid &&
                 ((bus.upd_taken != bus.upd_pred_taken) ||
                  (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

  assign bus.flush       = flush;
  assign bus.redirect_pc = bus.upd_taken ? bus.upd_target
                                         : bus.upd_pc + ADDR_W'(4);

  // Table write port; inval wins over a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        cnt_q[i]    <= CNT_WNT;
      end
    end else if (bus.inval) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (bus.upd_valid) begin
      if (up_hit) begin
        cnt_q[up_idx] <= up_cnt_nxt;
        if (bus.upd_taken) target_q[up_idx] <= bus.upd_target;
      end else if (bus.upd_taken) begin
        valid_q[up_idx]  <= 1'b1;
        tag_q[up_idx]    <= up_tag;
        target_q[up_idx] <= bus.upd_target;
        cnt_q[up_idx]    <= CNT_WT;
      end
    end
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_lk_q;
  logic [31:0] stat_mp_q;

  // Saturating event counters, cleared only by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_lk_q <= '0;
      stat_mp_q <= '0;
    end else begin
      if (stat_lk_q != 32'hFFFF_FFFF) stat_lk_q <= stat_lk_q + 32'd1;
      if (flush && (stat_mp_q != 32'hFFFF_FFFF)) stat_mp_q <= stat_mp_q + 32'd1;
    end
  end

  assign bus.stat_lookups     = stat_lk_q;
  assign bus.stat_mispredicts = stat_mp_q;
`else
  assign bus.stat_lookups     = '0;
  assign bus.stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (ENTRIES=16, ADDR_W=32, CNT_W=2).
module tb_btb_predictor;
  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_bad;

  btb_predictor_if #(.ADDR_W(32)) bus ();

  btb_predictor #(.ENTRIES(16), .ADDR_W(32), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                     input logic ptaken, input logic [31:0] ptgt);
    bus.upd_valid       = 1'b1;
    bus.upd_pc          = pc;
    bus.upd_taken       = taken;
    bus.upd_target      = tgt;
    bus.upd_pred_taken  = ptaken;
    bus.upd_pred_target = ptgt;
  endtask

  task automatic idle();
    bus.upd_valid       = 1'b0;
    bus.upd_pc          = '0;
    bus.upd_taken       = 1'b0;
    bus.upd_target      = '0;
    bus.upd_pred_taken  = 1'b0;
    bus.upd_pred_target = '0;
    bus.inval           = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input string tag, input logic [31:0] pc,
                      input logic exp_taken, input logic [31:0] exp_next);
    bus.lookup_pc = pc;
    #1;
    chk({tag, ".taken"}, {31'd0, bus.pred_taken}, {31'd0, exp_taken});
    chk({tag, ".next"}, bus.next_pc, exp_next);
  endtask

  // Train entry 0x100 with a taken/not-taken outcome that is predicted right.
  task automatic train(input logic taken, input logic [31:0] tgt);
    upd(32'h100, taken, tgt, taken, taken ? tgt : 32'h104);
    tick();
    idle();
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    idle();
    bus.lookup_pc = 32'h100;
    rst_n = 1'b0;

    // Reset: outputs quiet even with an update pending.
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h0);
    tick();
    tick();
    look("rst", 32'h100, 1'b0, 32'h104);
    chk("rst.flush", {31'd0, bus.flush}, 32'd0);
    chk("rst.stat_lk", bus.stat_lookups, 32'd0);
    chk("rst.stat_mp", bus.stat_mispredicts, 32'd0);
    idle();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Allocate 0x100 -> 0x40; same-cycle lookup still sees the old (empty) entry.
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    look("nobypass", 32'h100, 1'b0, 32'h104);
    chk("alloc.flush", {31'd0, bus.flush}, 32'd1);
    chk("alloc.redir", bus.redirect_pc, 32'h40);
    tick();
    idle();
    look("alloc.hit", 32'h100, 1'b1, 32'h40);          // cnt=2

    // Hysteresis and saturation.
    upd(32'h100, 1'b0, 32'h0, 1'b1, 32'h40);
    #1;
    chk("nt.flush", {31'd0, bus.flush}, 32'd1);
    chk("nt.redir", bus.redirect_pc, 32'h104);
    tick();
    idle();
    look("cnt1", 32'h100, 1'b0, 32'h104);              // cnt=1
    train(1'b1, 32'h40);                               // 2
    train(1'b1, 32'h40);                               // 3
    train(1'b1, 32'h40);                               // stays 3
    look("cnt3", 32'h100, 1'b1, 32'h40);
    train(1'b0, 32'h0);                                // 2
    look("sat.cnt2", 32'h100, 1'b1, 32'h40);
    train(1'b0, 32'h0);                                // 1
    look("sat.cnt1", 32'h100, 1'b0, 32'h104);
    train(1'b1, 32'h40);                               // 2

    // Correct predictions raise no flush.
    upd(32'h100, 1'b1, 32'h40, 1'b1, 32'h40);
    #1;
    chk("ok.t.flush", {31'd0, bus.flush}, 32'd0);
    upd(32'h100, 1'b0, 32'h0, 1'b0, 32'h104);
    #1;
    chk("ok.nt.flush", {31'd0, bus.flush}, 32'd0);
    idle();

    // Alias at index 0: 0x140 misses, then evicts 0x100.
    look("alias.miss", 32'h140, 1'b0, 32'h144);
    upd(32'h140, 1'b1, 32'h200, 1'b0, 32'h144);
    tick();
    idle();
    look("alias.hit", 32'h140, 1'b1, 32'h200);
    look("alias.evict", 32'h100, 1'b0, 32'h104);

    // Target change on a hit.
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    upd(32'h100, 1'b1, 32'h80, 1'b1, 32'h40);
    #1;
    chk("tgt.flush", {31'd0, bus.flush}, 32'd1);
    chk("tgt.redir", bus.redirect_pc, 32'h80);
    tick();
    idle();
    look("tgt.new", 32'h100, 1'b1, 32'h80);

    // Not-taken miss allocates nothing (0x180 aliases index 0).
    upd(32'h180, 1'b0, 32'h0, 1'b0, 32'h184);
    tick();
    idle();
    look("ntmiss.keep", 32'h100, 1'b1, 32'h80);
    look("ntmiss.miss", 32'h180, 1'b0, 32'h184);

    // Address wrap.
    look("wrap.next", 32'hFFFF_FFFC, 1'b0, 32'h0);
    upd(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h10);
    #1;
    chk("wrap.redir", bus.redirect_pc, 32'h0);
    chk("wrap.flush", {31'd0, bus.flush}, 32'd1);

    // inval drops a same-cycle allocate; flush still reported.
    upd(32'h244, 1'b1, 32'h300, 1'b0, 32'h248);
    bus.inval = 1'b1;
    #1;
    chk("inval.flush", {31'd0, bus.flush}, 32'd1);
    tick();
    idle();
    look("inval.new", 32'h244, 1'b0, 32'h248);
    look("inval.old", 32'h100, 1'b0, 32'h104);

    // Async reset mid-operation clears the table immediately.
    upd(32'h100, 1'b1, 32'h40, 1'b0, 32'h104);
    tick();
    idle();
    look("pre.arst", 32'h100, 1'b1, 32'h40);
    #1;
    rst_n = 1'b0;
    look("arst", 32'h100, 1'b0, 32'h104);

    // Stats: 10 cycles out of reset with 2 mispredicting updates.
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      idle();
      if (k == 3 || k == 7) upd(32'h10, 1'b1, 32'h20, 1'b0, 32'h14);
      else if (k == 5) upd(32'h10, 1'b0, 32'h0, 1'b0, 32'h14);
      tick();
    end
    idle();
`ifdef BTB_STATS_EN
    chk("stat.lk", bus.stat_lookups, 32'd10);
    chk("stat.mp", bus.stat_mispredicts, 32'd2);
`else
    chk("stat.lk", bus.stat_lookups, 32'd0);
    chk("stat.mp", bus.stat_mispredicts, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/btb_predictor.md
# btb_predictor

Parametrised branch target buffer with saturating-counter direction prediction. It supplies the IF stage with a predicted next fetch address, and is trained by the EX stage with each resolved branch/JAL outcome. It detects mispredictions and produces the flush request and redirect address for IF, IF/ID and ID/EX. It succeeds the fixed single-bit predict/flush path in the pipelined core, adding a tagged, direct-mapped table of configurable depth and counter width.

## Interface
- ENTRIES, 16: table depth; power of two, 2..256; IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC/target width.
- CNT_W, 2: counter width, 1..4.
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- lookup_pc  in  ADDR_W  current IF fetch address.
- pred_taken  out  1  lookup hit and counter MSB set.
- next_pc  out  ADDR_W  pred_taken ? stored target : lookup_pc+4.
- upd_valid  in  1  EX holds a resolved branch/JAL this cycle.
- upd_pc  in  ADDR_W  PC of that instruction.
- upd_taken  in  1  actual direction.
- upd_target  in  ADDR_W  actual taken target.
- upd_pred_taken  in  1  prediction carried down the pipeline with the instruction.
- upd_pred_target  in  ADDR_W  predicted next_pc carried down with the instruction.
- inval  in  1  clear all valid bits (fence.i / reprogram).
- flush  out  1  misprediction; kill IF/ID and ID/EX contents.
- redirect_pc  out  ADDR_W  correct next fetch address when flush=1.
- stat_lookups  out  32  lookup count (see Configuration).
- stat_mispredicts  out  32  flush count (see Configuration).

## Operation
- Entry: valid, tag = pc[ADDR_W-1:IDX_W+2], target, counter. Index = pc[IDX_W+1:2]; pc[1:0] are ignored.
- Lookup is combinational from the registered table. hit = valid && tag equal.
- Update (upd_valid=1) on a hit:
  - Counter saturating +1 if taken, -1 if not (range 0..2^CNT_W-1).
  - Target overwritten on a taken update.
- Update on a miss with upd_taken=1: allocate/replace the entry.
  - valid=1, tag and target loaded.
  - Counter = 2^(CNT_W-1), i.e. weakly taken.
- Update on a miss with upd_taken=0: no table change.
- flush = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- redirect_pc = upd_taken ? upd_target : upd_pc+4. This value is driven whenever upd_valid=1 and is don't-care otherwise.
- inval: all valid bits cleared. inval has priority over a same-cycle update, which is dropped. flush is still computed for that update.
- Arithmetic: +4 is modulo 2^ADDR_W; 0xFFFFFFFC+4 wraps to 0.

## Timing
- Reset:
  - All valid=0, targets=0, counters=2^(CNT_W-1)-1 (weakly not-taken; 0 when CNT_W=1).
  - Outputs: pred_taken=0, next_pc=lookup_pc+4, flush=0 (upd_valid is ignored during reset), stat counters=0.
- Reset asserted mid-operation clears the table immediately; any update in flight is lost.
- Lookup latency 0: outputs follow lookup_pc in the same cycle.
- Update and inval take effect at the rising edge; they are visible to lookups from the next cycle.
- No bypass: a lookup and an update to the same index in the same cycle sees the pre-update contents.
- flush/redirect_pc are combinational, in the same cycle as upd_valid. IF gives redirect_pc priority over next_pc.
- Exactly one write port; at most one update per cycle.

## Configuration
- BTB_STATS_EN defined:
  - stat_lookups increments every cycle out of reset.
  - stat_mispredicts increments every cycle flush=1.
  - Both are 32-bit, saturating at 0xFFFFFFFF, cleared only by rst_n.
- BTB_STATS_EN undefined: no counter registers; both ports tied to 0.

## Test plan
- Reset, lookup_pc=0x100 -> pred_taken=0, next_pc=0x104, flush=0; no stat increments while rst_n=0.
- Update pc=0x100, taken, target 0x40, pred_taken=0 -> flush=1, redirect_pc=0x40. Next cycle lookup 0x100 -> pred_taken=1, next_pc=0x40.
- CNT_W=2 hysteresis and saturation:
  - After allocation, one not-taken update -> counter 1, pred_taken=0.
  - Three taken updates -> counter 3.
  - One not-taken -> pred_taken still 1.
- Alias, ENTRIES=16: 0x100 allocated; lookup 0x140 (same index, other tag) -> miss, next_pc=0x144. Allocating 0x140 evicts 0x100.
- Target change: hit entry 0x100->0x40, update taken with target 0x80, upd_pred_target=0x40 -> flush=1, redirect_pc=0x80; later lookup returns 0x80.
- Corner cases:
  - inval with a same-cycle allocate -> all lookups miss next cycle.
  - Same-cycle lookup/update on the same PC -> old prediction returned.
  - With BTB_STATS_EN, 10 cycles containing 2 flushes -> stat_lookups=10, stat_mispredicts=2.
